// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: default widths, FSM state
// encoding and the requester identifier used by the round-robin pointer.
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF = 7;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        BOOT  = 2'd2
    } arbState_t;

    typedef enum logic {
        SIDE_CPU = 1'b0,
        SIDE_LD  = 1'b1
    } side_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between the processor and the program loader,
// with a loader-exclusive boot mode that drains outstanding reads first.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              boot,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              ld_req,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    output logic              ld_rvalid,
    output logic [DATA_W-1:0] ld_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              cpu_stall
);

    arbState_t         state;
    side_t             lastWinner;
    side_t             readTag;
    logic              readPend;
    logic [ADDR_W-1:0] addrHold;
    logic [DATA_W-1:0] wdataHold;
    logic              cpuWin;
    logic              ldWin;
    logic              readOut;

    always_comb begin
        cpuWin = 1'b0;
        ldWin  = 1'b0;
        if (!rst) begin
            case (state)
                RUN: begin
                    if (cpu_req && ld_req) begin
                        cpuWin = (lastWinner == SIDE_LD);
                        ldWin  = (lastWinner == SIDE_CPU);
                    end else begin
                        cpuWin = cpu_req;
                        ldWin  = ld_req;
                    end
                end
                DRAIN, BOOT: ldWin = ld_req;
                default: ;
            endcase
        end
    end

    // The hold registers are only cleared at the end of the first reset
    // cycle, so reset also forces the port to zero combinationally.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = addrHold;
        mem_wdata = wdataHold;
        if (rst) begin
            mem_addr  = '0;
            mem_wdata = '0;
        end else if (cpuWin) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (ldWin) begin
            mem_we    = ld_we;
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
        end
    end

    assign cpu_gnt    = cpuWin;
    assign ld_gnt     = ldWin;
    assign readOut    = readPend && !rst;
    assign cpu_rvalid = readOut && (readTag == SIDE_CPU);
    assign ld_rvalid  = readOut && (readTag == SIDE_LD);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign ld_rdata   = ld_rvalid ? mem_rdata : '0;
    assign cpu_stall  = !rst && (state != RUN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            lastWinner <= SIDE_LD;
            readTag    <= SIDE_CPU;
            readPend   <= 1'b0;
            addrHold   <= '0;
            wdataHold  <= '0;
        end else begin
            readPend <= (cpuWin && !cpu_we) || (ldWin && !ld_we);
            if (cpuWin || ldWin) begin
                lastWinner <= cpuWin ? SIDE_CPU : SIDE_LD;
                readTag    <= cpuWin ? SIDE_CPU : SIDE_LD;
                addrHold   <= mem_addr;
                wdataHold  <= mem_wdata;
            end
            case (state)
                RUN:     if (boot) state <= DRAIN;
                DRAIN: begin
                    if (!boot)          state <= RUN;
                    else if (!readPend) state <= BOOT;
                end
                BOOT:    if (!boot) state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed vector bench for mem_arbiter with a simple registered-read
// memory model attached to the shared port.
module tb_mem_arbiter;

    localparam int AW = 7;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst, boot;
    logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          ld_req, ld_we, ld_gnt, ld_rvalid;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata, ld_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_we, cpu_stall;
    logic          preload;

    logic [DW-1:0] mem [128];

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .boot(boot),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .cpu_stall(cpu_stall)
    );

    // Memory contents: word i holds 0x1000_0000+i, except word 5 = 0xAB
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 128; i++) mem[i] <= 32'h1000_0000 + i;
            mem[5] <= 32'h0000_00AB;
            mem_rdata <= '0;
        end else begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    typedef struct packed {
        logic          rst, boot, cReq, cWe;
        logic [AW-1:0] cAddr;
        logic [DW-1:0] cWd;
        logic          lReq, lWe;
        logic [AW-1:0] lAddr;
        logic [DW-1:0] lWd;
    } stim_t;

    typedef struct packed {
        logic          cG, lG, cRv, lRv;
        logic [DW-1:0] cRd, lRd;
        logic          mWe;
        logic [AW-1:0] mAddr;
        logic [DW-1:0] mWd;
        logic          stall;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    vec_t        vecs[$];
    int unsigned applied = 0;
    int unsigned miscompares = 0;

    function automatic stim_t st(input int unsigned r, b, cq, cw, ca, cd, lq, lw, la, ld);
        stim_t s;
        s.rst = 1'(r);   s.boot = 1'(b);
        s.cReq = 1'(cq); s.cWe = 1'(cw); s.cAddr = AW'(ca); s.cWd = DW'(cd);
        s.lReq = 1'(lq); s.lWe = 1'(lw); s.lAddr = AW'(la); s.lWd = DW'(ld);
        return s;
    endfunction

    function automatic exp_t ex(input int unsigned cg, lg, crv, lrv, crd, lrd, we, ad, wd, stl);
        exp_t e;
        e.cG = 1'(cg); e.lG = 1'(lg); e.cRv = 1'(crv); e.lRv = 1'(lrv);
        e.cRd = DW'(crd); e.lRd = DW'(lrd); e.mWe = 1'(we);
        e.mAddr = AW'(ad); e.mWd = DW'(wd); e.stall = 1'(stl);
        return e;
    endfunction

    task automatic add(input stim_t s, input exp_t e);
        vec_t v;
        v.s = s;
        v.e = e;
        vecs.push_back(v);
    endtask

    task automatic drive(input stim_t s);
        rst = s.rst; boot = s.boot;
        cpu_req = s.cReq; cpu_we = s.cWe; cpu_addr = s.cAddr; cpu_wdata = s.cWd;
        ld_req = s.lReq; ld_we = s.lWe; ld_addr = s.lAddr; ld_wdata = s.lWd;
    endtask

    task automatic checkOut(input string name, input exp_t e);
        exp_t a;
        a.cG = cpu_gnt; a.lG = ld_gnt; a.cRv = cpu_rvalid; a.lRv = ld_rvalid;
        a.cRd = cpu_rdata; a.lRd = ld_rdata; a.mWe = mem_we;
        a.mAddr = mem_addr; a.mWd = mem_wdata; a.stall = cpu_stall;
        applied++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s: got gnt=%b%b rv=%b%b crd=%h lrd=%h we=%b addr=%h wd=%h stall=%b, expected gnt=%b%b rv=%b%b crd=%h lrd=%h we=%b addr=%h wd=%h stall=%b",
                     name, a.cG, a.lG, a.cRv, a.lRv, a.cRd, a.lRd, a.mWe, a.mAddr, a.mWd, a.stall,
                     e.cG, e.lG, e.cRv, e.lRv, e.cRd, e.lRd, e.mWe, e.mAddr, e.mWd, e.stall);
        end
    endtask

    task automatic checkVal(input string name, input int unsigned got, input int unsigned want);
        applied++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    initial begin
        stim_t idle, rstS;
        exp_t  zero;
        int unsigned n;
        int unsigned gnts;

        idle = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rstS = st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        zero = ex(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // reset, single cpu read of word 5
        add(rstS, zero);
        add(rstS, zero);
        add(st(0, 0, 1, 0, 5, 0, 0, 0, 0, 0), ex(1, 0, 0, 0, 0, 0, 0, 5, 0, 0));
        add(idle, ex(0, 0, 1, 0, 32'hAB, 0, 0, 5, 0, 0));
        // round-robin after reset: CPU, LD, CPU, LD
        add(rstS, zero);
        add(st(0, 0, 1, 0, 10, 0, 1, 0, 20, 0), ex(1, 0, 0, 0, 0, 0, 0, 10, 0, 0));
        add(st(0, 0, 1, 0, 10, 0, 1, 0, 20, 0), ex(0, 1, 1, 0, 32'h1000_000A, 0, 0, 20, 0, 0));
        add(st(0, 0, 1, 0, 10, 0, 1, 0, 20, 0), ex(1, 0, 0, 1, 0, 32'h1000_0014, 0, 10, 0, 0));
        add(st(0, 0, 1, 0, 10, 0, 1, 0, 20, 0), ex(0, 1, 1, 0, 32'h1000_000A, 0, 0, 20, 0, 0));
        add(idle, ex(0, 0, 0, 1, 0, 32'h1000_0014, 0, 20, 0, 0));
        // loader write to top word, cpu reads it back
        add(st(0, 0, 0, 0, 0, 0, 1, 1, 7'h7F, 32'hDEAD_BEEF), ex(0, 1, 0, 0, 0, 0, 1, 7'h7F, 32'hDEAD_BEEF, 0));
        add(st(0, 0, 1, 0, 7'h7F, 0, 0, 0, 0, 0), ex(1, 0, 0, 0, 0, 0, 0, 7'h7F, 0, 0));
        add(idle, ex(0, 0, 1, 0, 32'hDEAD_BEEF, 0, 0, 7'h7F, 0, 0));
        // boot rises with a cpu read granted: drain, then loader burst
        add(st(0, 1, 1, 0, 5, 0, 0, 0, 0, 0), ex(1, 0, 0, 0, 0, 0, 0, 5, 0, 0));
        add(st(0, 1, 1, 0, 6, 0, 0, 0, 0, 0), ex(0, 0, 1, 0, 32'hAB, 0, 0, 5, 0, 1));
        add(st(0, 1, 1, 0, 6, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0, 5, 0, 1));
        for (int i = 0; i < 10; i++)
            add(st(0, 1, 1, 0, 6, 0, 1, 1, 32'h40 + i, 32'hA000_0000 + i),
                ex(0, 1, 0, 0, 0, 0, 1, 32'h40 + i, 32'hA000_0000 + i, 1));
        add(st(0, 0, 1, 0, 6, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0, 7'h49, 32'hA000_0009, 1));
        add(st(0, 0, 1, 0, 6, 0, 0, 0, 0, 0), ex(1, 0, 0, 0, 0, 0, 0, 6, 0, 0));
        // reset with a read outstanding
        add(rstS, zero);
        add(idle, zero);
        add(st(0, 0, 0, 0, 0, 0, 1, 0, 7'h45, 0), ex(0, 1, 0, 0, 0, 0, 0, 7'h45, 0, 0));
        add(idle, ex(0, 0, 0, 1, 0, 32'hA000_0005, 0, 7'h45, 0, 0));
        // boot dropped while still in DRAIN
        add(st(0, 1, 1, 0, 7, 0, 0, 0, 0, 0), ex(1, 0, 0, 0, 0, 0, 0, 7, 0, 0));
        add(idle, ex(0, 0, 1, 0, 32'h1000_0007, 0, 0, 7, 0, 1));
        add(st(0, 0, 1, 0, 8, 0, 0, 0, 0, 0), ex(1, 0, 0, 0, 0, 0, 0, 8, 0, 0));
        add(idle, ex(0, 0, 1, 0, 32'h1000_0008, 0, 0, 8, 0, 0));
        // tie with boot rising: loader wins by round-robin, serviced in DRAIN
        add(st(0, 1, 1, 0, 9, 0, 1, 0, 7'h45, 0), ex(0, 1, 0, 0, 0, 0, 0, 7'h45, 0, 0));
        add(st(0, 1, 1, 0, 9, 0, 0, 0, 0, 0), ex(0, 0, 0, 1, 0, 32'hA000_0005, 0, 7'h45, 0, 1));
        add(st(0, 0, 1, 0, 9, 0, 0, 0, 0, 0), ex(0, 0, 0, 0, 0, 0, 0, 7'h45, 0, 1));
        add(st(0, 0, 1, 0, 9, 0, 0, 0, 0, 0), ex(1, 0, 0, 0, 0, 0, 0, 9, 0, 0));
        add(idle, ex(0, 0, 1, 0, 32'h1000_0009, 0, 0, 9, 0, 0));

        preload = 1'b1;
        drive(rstS);
        @(negedge clk);
        preload = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].s);
            #2;
            checkOut($sformatf("vec%0d", i), vecs[i].e);
        end

        // boot with nothing outstanding: stall one cycle later, cpu locked out
        @(negedge clk);
        drive(st(0, 1, 1, 0, 3, 0, 0, 0, 0, 0));
        #2;
        checkVal("boot_gnt_same_cycle", cpu_gnt, 1);
        @(negedge clk);
        drive(st(0, 1, 1, 0, 3, 0, 0, 0, 0, 0));
        #2;
        @(negedge clk);
        #2;
        checkVal("read_done_stall", cpu_stall, 1);
        drive(st(0, 1, 1, 0, 4, 0, 0, 0, 0, 0));
        gnts = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #2;
            if (cpu_gnt) gnts++;
        end
        checkVal("boot_cpu_gnts", gnts, 0);
        checkVal("boot_stall", cpu_stall, 1);
        drive(st(0, 0, 1, 0, 4, 0, 0, 0, 0, 0));
        #1;
        n = 0;
        while (!cpu_gnt && n < 8) begin
            @(negedge clk);
            #2;
            n++;
        end
        checkVal("boot_exit_latency", n, 1);
        checkVal("run_stall", cpu_stall, 0);
        @(negedge clk);
        drive(idle);
        #2;
        checkVal("post_boot_rvalid", cpu_rvalid, 1);
        checkVal("post_boot_rdata", cpu_rdata, 32'h1000_0004);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
